writeback_stage: RTL and testbench

Parametrised writeback stage of the rv32 pipeline. It selects the result from the ALU value, the PC+4 link value or a load. It aligns and sign- or zero-extends byte, half and word loads. It waits for a memory response when the load data is not yet available, stalling the pipeline meanwhile, and drives a registered write port into the register file.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/writeback_stage_load_extender.sv | 49 ++++
 rtl/writeback_stage.sv | 116 +++++++++++
 tb/tb_writeback_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the rv32/rv64 writeback stage: result select, load size and FSM state.
package wb_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_PC4  = 2'd2,
      WB_RSVD = 2'd3
   } wb_sel_t;

   typedef enum logic [1:0] {
      LS_BYTE   = 2'd0,
      LS_HALF   = 2'd1,
      LS_WORD   = 2'd2,
      LS_DOUBLE = 2'd3
   } load_size_t;

   typedef enum logic {
      WB_IDLE     = 1'b0,
      WB_WAIT_MEM = 1'b1
   } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_extender.sv
// Combinational load aligner: shifts the addressed lane down, then sign/zero-extends
// the selected byte/half/word/double to XLEN and flags misaligned or illegal sizes.
module load_extender
   import wb_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int OFS_W = $clog2(XLEN/8)
) (
   input  logic [XLEN-1:0]  mem_data,
   input  logic [OFS_W-1:0] addr_ofs,
   input  load_size_t       load_size,
   input  logic             load_unsigned,
   output logic [XLEN-1:0]  value,
   output logic             misaligned
);

   logic [XLEN-1:0]        lane;
   logic [XLEN-1:0]        up;
   logic [XLEN-1:0]        zext;
   logic signed [XLEN-1:0] sext;
   logic [6:0]             shamt;

   // Left-justify the field, then shift back: logical for zero-, arithmetic for sign-extension.
   always_comb begin
      lane       = mem_data >> {addr_ofs, 3'b000};
      shamt      = 7'(XLEN - 8);
      misaligned = 1'b0;
      unique case (load_size)
         LS_BYTE:   shamt = 7'(XLEN - 8);
         LS_HALF: begin
            shamt      = 7'(XLEN - 16);
            misaligned = addr_ofs[0];
         end
         LS_WORD: begin
            shamt      = 7'(XLEN - 32);
            misaligned = |addr_ofs[1:0];
         end
         LS_DOUBLE: begin
            shamt      = 7'd0;
            misaligned = (XLEN == 32) || (|addr_ofs);
         end
      endcase
      up    = lane << shamt;
      zext  = up >> shamt;
      sext  = $signed(up) >>> shamt;
      value = load_unsigned ? zext : sext;
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects ALU/PC+4/load result, waits for late load data in WAIT_MEM
// and drives a registered register-file write port.
module writeback_stage
   import wb_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int OFS_W  = $clog2(XLEN/8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reg_write,
   input  logic [REG_AW-1:0] rd,
   input  logic [1:0]        wb_sel,
   input  logic [1:0]        load_size,
   input  logic              load_unsigned,
   input  logic [OFS_W-1:0]  addr_ofs,
   input  logic [XLEN-1:0]   alu_value,
   input  logic [XLEN-1:0]   pc_4_value,
   input  logic              mem_valid,
   input  logic [XLEN-1:0]   mem_data,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              stall,
   output logic              misalign_err
);

   wb_state_t state, state_nxt;
   wb_sel_t   sel;

   logic              p_reg_write, p_unsigned;
   logic [REG_AW-1:0] p_rd;
   logic [1:0]        p_size;
   logic [OFS_W-1:0]  p_ofs;

   logic              waiting, is_load, accept, ld_done, alu_done, go_wait;
   logic              wr_rw, wr_err, wr_en;
   logic [REG_AW-1:0] wr_rd;
   logic [XLEN-1:0]   wr_data, ext_value;
   logic              ext_mis;

   assign sel      = wb_sel_t'(wb_sel);
   assign waiting  = (state == WB_WAIT_MEM);
   assign is_load  = (sel == WB_MEM);
   assign accept   = in_valid && in_ready;
   assign ld_done  = mem_valid && (waiting || (accept && is_load));
   assign alu_done = accept && !is_load;
   assign go_wait  = accept && is_load && !mem_valid;

   // While waiting, the write uses the fields captured at accept, not the live inputs.
   assign wr_rd = waiting ? p_rd        : rd;
   assign wr_rw = waiting ? p_reg_write : reg_write;

   load_extender #(.XLEN(XLEN), .OFS_W(OFS_W)) u_ext (
      .mem_data      (mem_data),
      .addr_ofs      (waiting ? p_ofs : addr_ofs),
      .load_size     (load_size_t'(waiting ? p_size : load_size)),
      .load_unsigned (waiting ? p_unsigned : load_unsigned),
      .value         (ext_value),
      .misaligned    (ext_mis)
   );

   assign wr_err  = ld_done && ext_mis;
   assign wr_en   = (ld_done || alu_done) && wr_rw && (wr_rd != '0) && !wr_err;
   assign wr_data = ld_done ? ext_value : ((sel == WB_PC4) ? pc_4_value : alu_value);

   always_ff @(posedge clk) begin
      if (rst) state <= WB_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         WB_IDLE:     if (go_wait)   state_nxt = WB_WAIT_MEM;
         WB_WAIT_MEM: if (mem_valid) state_nxt = WB_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == WB_IDLE);
      stall    = (state == WB_WAIT_MEM) && !mem_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
         misalign_err <= 1'b0;
         p_reg_write  <= 1'b0;
         p_unsigned   <= 1'b0;
         p_rd         <= '0;
         p_size       <= '0;
         p_ofs        <= '0;
      end else begin
         rf_we        <= wr_en;
         misalign_err <= wr_err;
         if (wr_en) begin
            rf_waddr <= wr_rd;
            rf_wdata <= wr_data;
         end
         if (go_wait) begin
            p_reg_write <= reg_write;
            p_unsigned  <= load_unsigned;
            p_rd        <= rd;
            p_size      <= load_size;
            p_ofs       <= addr_ofs;
         end
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a 32-bit instance for the main scenarios and a
// 64-bit instance for double-word loads, all expectations hand-computed.
module tb_writeback_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 32-bit instance signals
   logic        in_valid, in_ready, reg_write, load_unsigned, mem_valid;
   logic [4:0]  rd, rf_waddr;
   logic [1:0]  wb_sel, load_size, addr_ofs;
   logic [31:0] alu_value, pc_4_value, mem_data, rf_wdata;
   logic        rf_we, stall, misalign_err;

   // 64-bit instance signals
   logic        in_valid64, in_ready64, reg_write64, load_unsigned64, mem_valid64;
   logic [4:0]  rd64, rf_waddr64;
   logic [1:0]  wb_sel64, load_size64;
   logic [2:0]  addr_ofs64;
   logic [63:0] alu_value64, pc_4_value64, mem_data64, rf_wdata64;
   logic        rf_we64, stall64, misalign_err64;

   writeback_stage #(.XLEN(32), .REG_AW(5)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .reg_write(reg_write), .rd(rd), .wb_sel(wb_sel), .load_size(load_size),
      .load_unsigned(load_unsigned), .addr_ofs(addr_ofs), .alu_value(alu_value),
      .pc_4_value(pc_4_value), .mem_valid(mem_valid), .mem_data(mem_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall(stall),
      .misalign_err(misalign_err)
   );

   writeback_stage #(.XLEN(64), .REG_AW(5)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
      .reg_write(reg_write64), .rd(rd64), .wb_sel(wb_sel64), .load_size(load_size64),
      .load_unsigned(load_unsigned64), .addr_ofs(addr_ofs64), .alu_value(alu_value64),
      .pc_4_value(pc_4_value64), .mem_valid(mem_valid64), .mem_data(mem_data64),
      .rf_we(rf_we64), .rf_waddr(rf_waddr64), .rf_wdata(rf_wdata64), .stall(stall64),
      .misalign_err(misalign_err64)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic op32(input logic v, input logic rw, input logic [4:0] r, input logic [1:0] sel,
                       input logic [1:0] sz, input logic u, input logic [1:0] ofs,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic mv, input logic [31:0] md);
      in_valid = v; reg_write = rw; rd = r; wb_sel = sel; load_size = sz;
      load_unsigned = u; addr_ofs = ofs; alu_value = alu; pc_4_value = pc4;
      mem_valid = mv; mem_data = md;
   endtask

   task automatic op64(input logic v, input logic [4:0] r, input logic [1:0] sz,
                       input logic u, input logic [2:0] ofs, input logic [63:0] md);
      in_valid64 = v; reg_write64 = 1'b1; rd64 = r; wb_sel64 = 2'd1; load_size64 = sz;
      load_unsigned64 = u; addr_ofs64 = ofs; alu_value64 = '0; pc_4_value64 = '0;
      mem_valid64 = 1'b1; mem_data64 = md;
   endtask

   task automatic idle32();
      op32(1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      idle32();
      op64(1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 64'h0);
      step(); step();
      chk("rst_we", rf_we, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_mis", misalign_err, 0);
      chk("rst_stall", stall, 0);
      chk("rst_ready", in_ready, 1);
      rst = 1'b0;

      // ALU then PC4 back-to-back
      op32(1, 1, 5'd5, 2'd0, 2'd0, 0, 2'd0, 32'h1234, 32'h0, 0, 32'h0);
      step();
      chk("alu_we", rf_we, 1);
      chk("alu_addr", rf_waddr, 5);
      chk("alu_data", rf_wdata, 32'h00001234);
      op32(1, 1, 5'd1, 2'd2, 2'd0, 0, 2'd0, 32'hBAD0, 32'h104, 0, 32'h0);
      step();
      chk("pc4_we", rf_we, 1);
      chk("pc4_addr", rf_waddr, 1);
      chk("pc4_data", rf_wdata, 32'h00000104);
      idle32();
      step();
      chk("we_one_cycle", rf_we, 0);

      // same-cycle byte/half loads
      op32(1, 1, 5'd10, 2'd1, 2'd0, 0, 2'd3, 0, 0, 1, 32'h80F1_7F02);
      step();
      chk("lb_we", rf_we, 1);
      chk("lb_data", rf_wdata, 32'hFFFFFF80);
      op32(1, 1, 5'd11, 2'd1, 2'd0, 1, 2'd3, 0, 0, 1, 32'h80F1_7F02);
      step();
      chk("lbu_data", rf_wdata, 32'h00000080);
      chk("lbu_addr", rf_waddr, 11);
      op32(1, 1, 5'd12, 2'd1, 2'd1, 0, 2'd2, 0, 0, 1, 32'h80F1_7F02);
      step();
      chk("lh_data", rf_wdata, 32'hFFFF80F1);
      op32(1, 1, 5'd13, 2'd1, 2'd1, 1, 2'd0, 0, 0, 1, 32'h80F1_7F02);
      step();
      chk("lhu_data", rf_wdata, 32'h00007F02);
      chk("lhu_mis", misalign_err, 0);

      // delayed memory: LW x7, data 3 cycles after accept
      op32(1, 1, 5'd7, 2'd1, 2'd2, 0, 2'd0, 0, 0, 0, 32'h0);
      step();
      idle32();
      #1;
      chk("dly_stall1", stall, 1);
      chk("dly_ready1", in_ready, 0);
      chk("dly_we1", rf_we, 0);
      step();
      chk("dly_stall2", stall, 1);
      chk("dly_ready2", in_ready, 0);
      step();
      chk("dly_stall3", stall, 1);
      chk("dly_ready3", in_ready, 0);
      mem_valid = 1'b1; mem_data = 32'hDEADBEEF;
      #1;
      chk("dly_stall_release", stall, 0);
      chk("dly_ready_mv", in_ready, 0);
      step();
      idle32();
      #1;
      chk("dly_we", rf_we, 1);
      chk("dly_addr", rf_waddr, 7);
      chk("dly_data", rf_wdata, 32'hDEADBEEF);
      chk("dly_ready_back", in_ready, 1);

      // misaligned loads leave the write port untouched
      op32(1, 1, 5'd8, 2'd1, 2'd2, 0, 2'd2, 0, 0, 1, 32'h1111_2222);
      step();
      chk("mis_lw_err", misalign_err, 1);
      chk("mis_lw_we", rf_we, 0);
      chk("mis_lw_addr", rf_waddr, 7);
      chk("mis_lw_data", rf_wdata, 32'hDEADBEEF);
      op32(1, 1, 5'd9, 2'd1, 2'd1, 0, 2'd1, 0, 0, 1, 32'h1111_2222);
      step();
      chk("mis_lh_err", misalign_err, 1);
      chk("mis_lh_we", rf_we, 0);
      op32(1, 1, 5'd9, 2'd1, 2'd3, 0, 2'd0, 0, 0, 1, 32'h1111_2222);
      step();
      chk("ld_on_rv32_err", misalign_err, 1);
      chk("ld_on_rv32_data", rf_wdata, 32'hDEADBEEF);
      idle32();
      step();
      chk("mis_pulse_end", misalign_err, 0);

      // write to x0 suppressed
      op32(1, 1, 5'd0, 2'd0, 2'd0, 0, 2'd0, 32'h55, 0, 0, 0);
      step();
      chk("x0_we", rf_we, 0);
      chk("x0_ready", in_ready, 1);
      chk("x0_data", rf_wdata, 32'hDEADBEEF);

      // reserved select behaves as ALU
      op32(1, 1, 5'd3, 2'd3, 2'd0, 0, 2'd0, 32'hABC, 32'h999, 0, 0);
      step();
      chk("rsvd_data", rf_wdata, 32'h00000ABC);
      chk("rsvd_mis", misalign_err, 0);

      // reset while waiting drops the pending load
      op32(1, 1, 5'd9, 2'd1, 2'd2, 0, 2'd0, 0, 0, 0, 0);
      step();
      idle32();
      #1;
      chk("rstw_stall", stall, 1);
      rst = 1'b1; mem_valid = 1'b1; mem_data = 32'h0000_0011;
      step();
      rst = 1'b0;
      chk("rstw_we", rf_we, 0);
      chk("rstw_stall_after", stall, 0);
      chk("rstw_ready", in_ready, 1);
      idle32();

      // 64-bit instance
      op64(1, 5'd4, 2'd0, 0, 3'd3, 64'hFEDC_BA98_80F1_7F02);
      step();
      chk("x64_lb", rf_wdata64, 64'hFFFF_FFFF_FFFF_FF80);
      op64(1, 5'd4, 2'd1, 1, 3'd0, 64'hFEDC_BA98_80F1_7F02);
      step();
      chk("x64_lhu", rf_wdata64, 64'h0000_0000_0000_7F02);
      op64(1, 5'd4, 2'd2, 0, 3'd4, 64'hFEDC_BA98_80F1_7F02);
      step();
      chk("x64_lw", rf_wdata64, 64'hFFFF_FFFF_FEDC_BA98);
      op64(1, 5'd4, 2'd2, 1, 3'd4, 64'hFEDC_BA98_80F1_7F02);
      step();
      chk("x64_lwu", rf_wdata64, 64'h0000_0000_FEDC_BA98);
      op64(1, 5'd6, 2'd3, 0, 3'd0, 64'hFEDC_BA98_80F1_7F02);
      step();
      chk("x64_ld_we", rf_we64, 1);
      chk("x64_ld_data", rf_wdata64, 64'hFEDC_BA98_80F1_7F02);
      chk("x64_ld_mis", misalign_err64, 0);
      op64(1, 5'd7, 2'd3, 0, 3'd4, 64'h0123_4567_89AB_CDEF);
      step();
      chk("x64_ld4_mis", misalign_err64, 1);
      chk("x64_ld4_we", rf_we64, 0);
      chk("x64_ld4_data", rf_wdata64, 64'hFEDC_BA98_80F1_7F02);
      op64(0, 5'd0, 2'd0, 0, 3'd0, 64'h0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
